// File: rtl/data_memory.sv
// data_memory: single-port word-addressed RAM with registered, write-first read data.
module data_memory #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  localparam int DEPTH = 2 ** ADDR_W;
  logic [DATA_W-1:0] mem [DEPTH];
  // Every edge is an access; the caller gates clk to suppress accesses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem   <= '{default: '0};
      rdata <= '0;
    end else if (we) begin
      mem[addr] <= wdata;
      rdata     <= wdata;
    end else begin
      rdata <= mem[addr];
    end
  end
endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory: scoreboard bench for data_memory with a gated clock and array reference model.
module tb_data_memory;
  logic        ck = 1'b0, en = 1'b0, rst_n = 1'b1, we = 1'b0;
  logic        clk;
  logic [7:0]  addr = '0;
  logic [31:0] wdata = '0, rdata;
  logic [31:0] model [256];
  logic [31:0] exp_q [$];
  int tests = 0, fails = 0;

  assign clk = ck & en;
  always #5 ck = ~ck;

  data_memory #(.DATA_W(32), .ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .we(we), .addr(addr), .wdata(wdata), .rdata(rdata)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every gated edge must match the oldest outstanding expectation.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL unexpected_edge: got %h, expected no access", rdata);
    end else begin
      check("rdata", rdata, exp_q.pop_front());
    end
  end

  // Called with ck low; enables exactly one clk edge.
  task automatic access(input bit w, input logic [7:0] a, input logic [31:0] d);
    we = w;
    addr = a;
    wdata = d;
    if (w) begin
      model[a] = d;
      exp_q.push_back(d);
    end else begin
      exp_q.push_back(model[a]);
    end
    en = 1'b1;
    @(posedge ck);
    @(negedge ck);
    en = 1'b0;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 256; i++) model[i] = '0;
  endtask

  task automatic reset_pulse();
    #2 rst_n = 1'b0;
    #1 check("reset_async", rdata, 32'h0);
    clear_model();
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #3 rst_n = 1'b0;
    #1 check("reset_initial", rdata, 32'h0);
    clear_model();
    #3 rst_n = 1'b1;
    @(negedge ck);
    access(0, 8'h00, '0);
    access(0, 8'h7F, '0);
    access(0, 8'hFF, '0);
    access(1, 8'h10, 32'hDEADBEEF);
    access(0, 8'h11, '0);
    access(0, 8'h10, '0);
    access(1, 8'h00, 32'h00000001);
    access(1, 8'hFF, 32'h80000000);
    access(0, 8'h00, '0);
    access(0, 8'hFF, '0);
    access(0, 8'h01, '0);
    access(0, 8'hFE, '0);
    access(1, 8'h20, 32'h12345678);
    access(1, 8'h20, 32'h9ABCDEF0);
    access(0, 8'h20, '0);
    addr = 8'h10;
    #1 check("hold_addr_change", rdata, 32'h9ABCDEF0);
    repeat (3) @(negedge ck);
    check("hold_idle", rdata, 32'h9ABCDEF0);
    for (int k = 0; k < 16; k++) access(1, 8'(k), 32'hA5A5A5A5);
    reset_pulse();
    @(negedge ck);
    for (int k = 0; k < 16; k++) access(0, 8'(k), '0);
    for (int k = 0; k < 256; k++) access(1, 8'(k), 32'(k) * 32'h01010101);
    for (int k = 0; k < 256; k++) access(0, 8'(k), '0);
    for (int n = 0; n < 300; n++)
      access(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), $urandom);
    access(1, 8'h33, 32'h0F0F0F0F);
    access(0, 8'h33, '0);
    @(negedge ck);
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/data_memory.md
Name: data_memory

Overview:
- Synchronous single-port data RAM for the MEM stage of the pipelined CPU.
- The stage drives it with:
  - the phase-0 clock gated by (write-enable OR read-enable);
  - the low 8 bits of the ALU result as the word address;
  - register B data as write data.
- The registered read output is captured into the stage's pipeline register on a later clock phase.

Parameters:
- DATA_W, 32, data word width in bits
- ADDR_W, 8, address width; depth = 2**ADDR_W words (256)

Ports:
- clk    input   1       clock, rising-edge active; the caller gates it so an edge occurs only on a memory access
- rst_n  input   1       asynchronous, active-low reset
- we     input   1       write enable: 1 = write, 0 = read
- addr   input   ADDR_W  word address (word-indexed, not byte-indexed)
- wdata  input   DATA_W  write data
- rdata  output  DATA_W  registered read data

Behaviour:
- Storage: DEPTH words of DATA_W bits, mem[0..DEPTH-1].
- Reset, when rst_n = 0, asynchronous and independent of clk:
  - every mem word cleared to 0;
  - rdata cleared to 0.
  - While rst_n is held low, clk edges have no effect.
- The first clk edge after rst_n rises behaves normally.
- Write, on posedge clk with we = 1:
  - mem[addr] <= wdata;
  - rdata <= wdata (write-first; the output shows the data just written).
- Read, on posedge clk with we = 0:
  - rdata <= mem[addr], the value before this edge;
  - mem is unchanged.
- Latency: 1 clk edge from addr/wdata sampling to rdata valid.
- Between edges, rdata holds its value; it never changes combinationally with addr.
- No internal enable: every clk edge is an access. Access suppression is done solely by clock gating in the caller.
- Address range: all 2**ADDR_W addresses are valid. No wrap-around or out-of-range case exists within ADDR_W bits.
- Back-to-back write then read of the same address on consecutive edges returns the newly written data.
- Reset asserted between two edges: the next read after reset release returns 0 at any address.
- X on we or addr at an edge is not permitted.
- Initial (pre-reset) contents are undefined; the bench must apply reset first.

Test Plan:
1. Reset: drive rst_n = 0 with no clk edge -> rdata = 0 immediately. Release, then read addr 0x00, 0x7F and 0xFF -> rdata = 0x00000000 each.
2. Write/read: write 0xDEADBEEF to addr 0x10 -> rdata = 0xDEADBEEF after that edge. Read addr 0x11 -> 0x00000000. Read addr 0x10 -> 0xDEADBEEF.
3. Boundary addresses: write 0x00000001 to 0x00 and 0x80000000 to 0xFF. Read both -> exact values back; addr 0x01 and 0xFE remain 0.
4. Overwrite and read latency: write 0x12345678 then 0x9ABCDEF0 to addr 0x20, then read -> 0x9ABCDEF0. Change addr between edges -> rdata unchanged until the next edge.
5. Async reset mid-operation: after filling addr 0x00-0x0F with 0xA5A5A5A5, pulse rst_n low between edges -> rdata = 0 at once. Subsequent reads of 0x00-0x0F -> 0.
6. Fill/sweep: write each addr k (0..255) with the value (k * 0x01010101). Read all 256 addresses back in order -> each matches, with a one-edge latency per access.
